draw_sequencer: RTL

Command sequencer that sits directly upstream of the rectangle drawer. It accepts draw, erase and move requests for press and garbage items through a valid/ready handshake and buffers them in a small FIFO. It then drives the drawer's item, erase, position and reset inputs so that each rectangle is scanned exactly once from a clean counter origin. It also produces a plot gate that the top level ANDs with the drawer's plot output before the VGA adapter's writeEn.

---
 rtl/draw_sequencer_if.sv | 28 ++
 rtl/draw_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sequencer_if
//  Description : Command handshake bundle between a command source and the
//                draw sequencer (valid/ready plus the 9-bit command fields).
//  Revision    : 1.0 - initial release
// ============================================================================
interface draw_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_item;
    logic [2:0] cmd_position;
    logic [2:0] cmd_old_position;

    // Command source side
    modport master (
        output cmd_valid, cmd_op, cmd_item, cmd_position, cmd_old_position,
        input  cmd_ready
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_item, cmd_position, cmd_old_position,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sequencer
//  Description : Buffers draw/erase/move commands in a small FIFO and drives
//                the rectangle drawer so every rectangle is scanned exactly
//                once from a clean counter origin, with a matching plot gate.
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
    parameter int PRESS_PIXELS   = 2400,
    parameter int GARBAGE_PIXELS = 400,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    draw_sequencer_if.slave cmd,
    output logic            drw_item,
    output logic            drw_erase,
    output logic [2:0]      drw_position,
    output logic            drw_reset_n,
    output logic            plot_en,
    output logic            busy,
    output logic            done
);

    localparam int            c_AW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0] c_DEPTH      = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [11:0]   c_PRESS_LAST = 12'(PRESS_PIXELS - 1);
    localparam logic [11:0]   c_GARB_LAST  = 12'(GARBAGE_PIXELS - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_RESTART = 3'd2;
    localparam logic [2:0] c_ST_RUN     = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    localparam logic [1:0] c_PH_DRAW      = 2'd0;
    localparam logic [1:0] c_PH_ERASE     = 2'd1;
    localparam logic [1:0] c_PH_ERASE_OLD = 2'd2;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {op[8:7], item[6], position[5:3], old[2:0]}
    // ------------------------------------------------------------------
    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_fifo_cnt, w_fifo_cnt_nxt;
    logic            w_full, w_empty, w_push, w_pop;
    logic [8:0]      w_head;

    // ------------------------------------------------------------------
    // Sequencer state and working copy of the command being executed
    // ------------------------------------------------------------------
    logic [2:0]  r_state, w_state_nxt;
    logic [11:0] r_count, w_count_nxt;
    logic [1:0]  r_phase, w_phase_nxt;
    logic [1:0]  r_op, w_op_nxt;
    logic        r_item, w_item_nxt;
    logic [2:0]  r_pos, w_pos_nxt;
    logic [2:0]  r_old, w_old_nxt;
    logic [11:0] w_last;

    assign w_full        = (r_fifo_cnt == c_DEPTH);
    assign w_empty       = (r_fifo_cnt == '0);
    assign cmd.cmd_ready = !w_full && !reset;
    assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
    // The head is consumed on the edge that enters LOAD, so LOAD already
    // holds the command and the freed slot is visible one cycle sooner.
    assign w_pop         = (w_state_nxt == c_ST_LOAD);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_last        = r_item ? c_PRESS_LAST : c_GARB_LAST;

    // Next FIFO occupancy, used for the registered busy flag
    always_comb begin
        w_fifo_cnt_nxt = r_fifo_cnt;
        case ({w_push, w_pop})
            2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + 1'b1;
            2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - 1'b1;
            default: w_fifo_cnt_nxt = r_fifo_cnt;
        endcase
    end

    // FIFO storage: written on every accepted command, never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_item, cmd.cmd_position, cmd.cmd_old_position};
        end
    end

    // FIFO pointers and occupancy; reset discards everything queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fifo_cnt <= w_fifo_cnt_nxt;
        end
    end

    // Next-state, pixel counter, phase and command latch decisions
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_phase_nxt = r_phase;
        w_op_nxt    = r_op;
        w_item_nxt  = r_item;
        w_pos_nxt   = r_pos;
        w_old_nxt   = r_old;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) w_state_nxt = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_state_nxt = (r_op == 2'b11) ? c_ST_DONE : c_ST_RESTART;
            end
            c_ST_RESTART: begin
                w_state_nxt = c_ST_RUN;
                w_count_nxt = '0;
            end
            c_ST_RUN: begin
                if (r_count == w_last) begin
                    if (r_phase == c_PH_ERASE_OLD) begin
                        w_phase_nxt = c_PH_DRAW;
                        w_state_nxt = c_ST_RESTART;
                    end else begin
                        w_state_nxt = c_ST_DONE;
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = w_empty ? c_ST_IDLE : c_ST_LOAD;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // Latch the FIFO head and pick the first phase when a command loads
        if (w_state_nxt == c_ST_LOAD) begin
            w_op_nxt   = w_head[8:7];
            w_item_nxt = w_head[6];
            w_pos_nxt  = w_head[5:3];
            w_old_nxt  = w_head[2:0];
            case (w_head[8:7])
                2'b10:   w_phase_nxt = c_PH_ERASE_OLD;
                2'b01:   w_phase_nxt = c_PH_ERASE;
                default: w_phase_nxt = c_PH_DRAW;
            endcase
        end
    end

    // State registers and registered drawer/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_count      <= '0;
            r_phase      <= c_PH_DRAW;
            r_op         <= 2'b00;
            r_item       <= 1'b0;
            r_pos        <= 3'd0;
            r_old        <= 3'd0;
            drw_item     <= 1'b0;
            drw_erase    <= 1'b0;
            drw_position <= 3'd0;
            drw_reset_n  <= 1'b0;
            plot_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_phase      <= w_phase_nxt;
            r_op         <= w_op_nxt;
            r_item       <= w_item_nxt;
            r_pos        <= w_pos_nxt;
            r_old        <= w_old_nxt;
            drw_item     <= w_item_nxt;
            drw_erase    <= (w_phase_nxt != c_PH_DRAW);
            drw_position <= (w_phase_nxt == c_PH_ERASE_OLD) ? w_old_nxt : w_pos_nxt;
            drw_reset_n  <= (w_state_nxt == c_ST_RUN);
            plot_en      <= (w_state_nxt == c_ST_RUN);
            busy         <= (w_state_nxt != c_ST_IDLE) || (w_fifo_cnt_nxt != '0);
            done         <= (w_state_nxt == c_ST_DONE);
        end
    end

endmodule
`default_nettype wire
